// File: rtl/rom_scan_pkg.sv
// Shared types and constants for the coefficient-table scan reader:
// table geometry, FSM states, buffered beat layout and the JPEG zigzag map.
package rom_scan_pkg;

    localparam int TBL_DEPTH = 64;
    localparam int IDX_W     = 6;
    localparam int DATA_W    = 8;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TBL_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic              last;
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
    } beat_t;

    // Scan position -> raster address of the 8x8 block in JPEG zigzag order.
    localparam logic [IDX_W-1:0] ZZ_TAB [TBL_DEPTH] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    function automatic logic [IDX_W-1:0] zz_addr(input logic [IDX_W-1:0] idx);
        return ZZ_TAB[idx];
    endfunction

endpackage

// File: rtl/scan_skid_fifo.sv
// Small circular buffer holding {last,index,data} beats between the ROM capture
// and the downstream interface; the head is presented combinationally.
module scan_skid_fifo
    import rom_scan_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  beat_t            push_beat_i,
    input  logic             pop_i,
    output beat_t            head_o,
    output logic [CNT_W-1:0] count_o
);

    beat_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: storage has no reset; an empty buffer masks it to zero at the head,
    // so only pointers and count need to come out of reset defined.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_beat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/rom_scan_reader.sv
// Walks the 64-entry coefficient ROM in raster or zigzag order and streams it
// out as valid/ready beats, crediting ROM reads against free buffer space.
module rom_scan_reader
    import rom_scan_pkg::*;
#(
    parameter int SKID_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              zigzag,
    input  logic              abort,
    output logic [IDX_W-1:0]  rom_a,
    input  logic [DATA_W-1:0] rom_d,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    state_e           state_q;
    logic [IDX_W-1:0] issue_idx_q;
    logic [IDX_W-1:0] tag_idx_q;
    logic             in_flight_q;
    logic             zz_mode_q;
    logic [IDX_W-1:0] rom_a_q;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] fifo_count;
    beat_t            head;
    beat_t            push_beat;
    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occupancy;

    // A read is only launched when its byte is guaranteed a buffer slot,
    // counting the read already in flight and the beat leaving this cycle.
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(in_flight_q) - OCC_W'(pop);
    assign issue     = (state_q == RUN) && !abort && (occupancy < OCC_W'(SKID_DEPTH));

    assign push      = in_flight_q && !abort;
    assign push_beat = '{last: (tag_idx_q == LAST_IDX), index: tag_idx_q, data: rom_d};

    scan_skid_fifo #(
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (abort),
        .push_i      (push),
        .push_beat_i (push_beat),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // later assignments in the block override the defaults above them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_idx_q <= '0;
            tag_idx_q   <= '0;
            in_flight_q <= 1'b0;
            zz_mode_q   <= 1'b0;
            rom_a_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            in_flight_q <= issue;

            if (issue) begin
                rom_a_q   <= zz_mode_q ? zz_addr(issue_idx_q) : issue_idx_q;
                tag_idx_q <= issue_idx_q;
                if (issue_idx_q != LAST_IDX) begin
                    issue_idx_q <= issue_idx_q + 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        zz_mode_q   <= zigzag;
                        issue_idx_q <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (issue && (issue_idx_q == LAST_IDX)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (pop && head.last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_a     = rom_a_q;
    assign out_data  = head.data;
    assign out_index = head.index;
    assign out_last  = head.last;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rom_scan_reader.sv
// Scoreboard bench for rom_scan_reader: a ROM model with the known table bytes,
// an algorithmic zigzag reference, randomized back-pressure, abort and reset cases.
module tb_rom_scan_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       zigzag;
    logic       abort;
    logic [5:0] rom_a;
    logic [7:0] rom_d;
    logic [7:0] out_data;
    logic [5:0] out_index;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    rom_scan_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .zigzag    (zigzag),
        .abort     (abort),
        .rom_a     (rom_a),
        .rom_d     (rom_d),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Table ROM: rom_a is the ROM's address register, so data follows it directly.
    logic [7:0] rom_mem [64];
    assign rom_d = rom_mem[rom_a];

    typedef struct {
        logic [7:0] data;
        logic [5:0] index;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   zz_ref [64];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_xfer_cyc = 0;
    int last_beat_cyc = 0;
    int scan_xfers    = 0;

    logic        stab_en  = 1'b1;
    logic        gap_en   = 1'b0;
    logic        bound_en = 1'b0;
    logic        rand_mode   = 1'b0;
    logic        ready_level = 1'b1;
    logic        prev_stall  = 1'b0;
    logic [14:0] prev_beat   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic void build_refs();
        int r = 0;
        int c = 0;
        for (int i = 0; i < 64; i++) rom_mem[i] = 8'(8'hE7 - i * 3);
        rom_mem[0]  = 8'hFF;  rom_mem[1]  = 8'h80;  rom_mem[2]  = 8'h6C;
        rom_mem[3]  = 8'h5D;  rom_mem[8]  = 8'h80;  rom_mem[9]  = 8'h80;
        rom_mem[16] = 8'h6C;  rom_mem[63] = 8'h19;
        // Zigzag derived by walking the anti-diagonals of the 8x8 block.
        for (int k = 0; k < 64; k++) begin
            zz_ref[k] = r * 8 + c;
            if (((r + c) % 2) == 0) begin
                if (c == 7) r++;
                else if (r == 0) c++;
                else begin r--; c++; end
            end else begin
                if (r == 7) c++;
                else if (c == 0) r++;
                else begin r++; c--; end
            end
        end
    endfunction

    function automatic void push_scan(input logic zz);
        exp_t e;
        for (int k = 0; k < 64; k++) begin
            e.index = 6'(k);
            e.data  = rom_mem[zz ? zz_ref[k] : k];
            e.last  = (k == 63);
            exp_q.push_back(e);
        end
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_mode ? ($urandom_range(0, 99) < 30) : ready_level;
        end
    end

    // Monitor: compares every transferred beat against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (stab_en && prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_beat", {out_last, out_index, out_data}, prev_beat);
            end
            if (bound_en && scan_xfers > 0)
                check("skid_bound", ((int'(rom_a) + 1 - scan_xfers) <= 2), 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_beat");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_index", out_index, mon_e.index);
                    check("beat_data", out_data, mon_e.data);
                    check("beat_last", out_last, mon_e.last);
                    if (gap_en && mon_e.index != 0) check("no_gap", cyc - last_xfer_cyc, 1);
                    last_xfer_cyc = cyc;
                    if (mon_e.index == 0) scan_xfers = 0;
                    scan_xfers++;
                    if (mon_e.last) last_beat_cyc = cyc;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_last, out_index, out_data};
        end
    end

    task automatic start_scan(input logic zz);
        @(posedge clk);
        #1;
        start  = 1'b1;
        zigzag = zz;
        push_scan(zz);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        check(name, out_valid, 1);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        check(name, done, 1);
    endtask

    initial begin
        int c0;
        int seen;
        build_refs();
        rst_n  = 1'b0;
        start  = 1'b0;
        zigzag = 1'b0;
        abort  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_index", out_index, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rom_a", rom_a, 0);
        rst_n = 1'b1;

        // Raster, ready held high: latency, back-to-back beats, done timing
        gap_en = 1'b1; bound_en = 1'b1;
        start_scan(1'b0);
        c0 = cyc;
        @(negedge clk);
        check("t1_busy", busy, 1);
        wait_valid(20, "t1_first_valid");
        check("t1_latency", cyc - c0, 2);
        wait_done(200, "t1_done");
        check("t1_done_after_last", cyc - last_beat_cyc, 1);
        check("t1_busy_clear", busy, 0);
        check("t1_drained", exp_q.size(), 0);
        @(negedge clk);
        check("t1_done_pulse", done, 0);

        // Zigzag, ready held high: address order
        bound_en = 1'b0;
        start_scan(1'b1);
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t2_rom_a", rom_a, zz_ref[k]);
        end
        wait_done(200, "t2_done");
        check("t2_drained", exp_q.size(), 0);

        // Random back-pressure, raster then zigzag (zigzag toggled mid-scan)
        gap_en = 1'b0; bound_en = 1'b1; rand_mode = 1'b1;
        start_scan(1'b0);
        wait_done(3000, "t3_done");
        check("t3_drained", exp_q.size(), 0);
        bound_en = 1'b0;
        start_scan(1'b1);
        repeat (5) @(negedge clk);
        zigzag = 1'b0;
        wait_done(3000, "t4_done");
        check("t4_drained", exp_q.size(), 0);
        rand_mode = 1'b0;

        // Ready low for 20 cycles from first valid
        ready_level = 1'b0; gap_en = 1'b1; bound_en = 1'b1;
        start_scan(1'b0);
        wait_valid(20, "t5_first_valid");
        repeat (19) @(negedge clk);
        check("t5_stalled_valid", out_valid, 1);
        check("t5_stalled_index", out_index, 0);
        check("t5_issued_two", rom_a, 1);
        ready_level = 1'b1;
        wait_done(200, "t5_done");
        check("t5_drained", exp_q.size(), 0);

        // Abort with the buffer full
        gap_en = 1'b0; bound_en = 1'b0;
        start_scan(1'b0);
        seen = 0;
        while (seen < 200 && !(out_valid && out_index == 6'd10)) begin
            @(negedge clk);
            seen++;
        end
        check("t6_reach_beat10", out_index, 10);
        ready_level = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_buffer_held", out_valid, 1);
        stab_en = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("t6_abort_valid", out_valid, 0);
        check("t6_abort_busy", busy, 0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("t6_abort_no_done", seen, 0);
        ready_level = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_abort_beats_start", busy, 0);
        check("t6_abort_beats_valid", out_valid, 0);
        stab_en = 1'b1;
        start_scan(1'b0);
        wait_valid(20, "t6_restart_valid");
        check("t6_restart_index", out_index, 0);
        check("t6_restart_data", out_data, 8'hFF);
        wait_done(200, "t6_restart_done");
        check("t6_drained", exp_q.size(), 0);

        // Asynchronous reset mid-scan
        start_scan(1'b1);
        repeat (20) @(negedge clk);
        stab_en = 1'b0;
        #2;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", out_valid, 0);
        check("t7_rst_data", out_data, 0);
        check("t7_rst_index", out_index, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_rom_a", rom_a, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("t7_rst_no_done", seen, 0);
        rst_n = 1'b1;
        stab_en = 1'b1;

        // start while busy is ignored; a full scan follows after done
        start_scan(1'b0);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200, "t8_done");
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1;
        end
        check("t8_no_second_scan", seen, 0);
        check("t8_drained", exp_q.size(), 0);
        rand_mode = 1'b1;
        start_scan(1'b1);
        wait_done(3000, "t8_full_scan_done");
        check("t8_full_drained", exp_q.size(), 0);
        rand_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
